dtcp_arbiter: RTL and testbench

DTCP_ARBITER -- requirements
Module: dtcp_arbiter

---
 rtl/dtcp_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dtcp_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtcp_arbiter.sv
// -----------------------------------------------------------------------------
// dtcp_arbiter
//
// Purpose
//   Two-requester round-robin arbiter in front of a single data-copy engine.
//   A granted requester's packet word count is latched and presented to the
//   engine together with a one-cycle start pulse. The arbiter then waits for
//   the engine's completion pulse (or a timeout) and returns a one-cycle done
//   pulse to the owner, flagged with oErr when the job failed. A job fails
//   when its size is illegal (0 or above 0x200 words) or when the engine does
//   not answer within P_TOCYC cycles.
//
// Parameters
//   P_TOCYC      WAIT-state timeout in clock cycles (1..2047).
//
// Ports
//   iClk         clock, rising edge
//   iRsn         synchronous active-low reset
//   iReq0/1      copy request, level, held until the matching oDone pulse
//   iPktWdSize0/1 packet word count of requester 0/1
//   oGnt0/1      requester owns the engine (START, WAIT, DONE, ERR)
//   oDone0/1     one-cycle completion pulse to the owner
//   oErr         one-cycle failure flag, coincident with oDone0/1
//   oStDtCp      one-cycle engine start pulse
//   oPktWdSize   word count presented to the engine (latched at grant)
//   iDtCpDone    one-cycle engine completion pulse
//   oBusy        high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module dtcp_arbiter #(
    parameter logic [10:0] P_TOCYC = 11'd1100
) (
    input  logic       iClk,
    input  logic       iRsn,
    input  logic       iReq0,
    input  logic [9:0] iPktWdSize0,
    output logic       oGnt0,
    output logic       oDone0,
    input  logic       iReq1,
    input  logic [9:0] iPktWdSize1,
    output logic       oGnt1,
    output logic       oDone1,
    output logic       oErr,
    output logic       oStDtCp,
    output logic [9:0] oPktWdSize,
    input  logic       iDtCpDone,
    output logic       oBusy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Last counter value that still counts as "in time".
    localparam logic [10:0] TO_LAST = P_TOCYC - 11'd1;

    // Largest legal packet size in words.
    localparam logic [9:0] SIZE_MAX = 10'h200;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        last_q,  last_d;     // last served requester
    logic        gnt_id_q, gnt_id_d;  // current owner
    logic [9:0]  size_q,  size_d;     // latched packet size
    logic [10:0] cnt_q,   cnt_d;      // WAIT timeout counter

    logic gnt0_q, gnt0_d;
    logic gnt1_q, gnt1_d;
    logic done0_q, done0_d;
    logic done1_q, done1_d;
    logic err_q,  err_d;
    logic st_q,   st_d;
    logic busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       any_req;
    logic       win_id;
    logic [9:0] win_size;
    logic       win_bad;

    always_comb begin
        any_req = iReq0 | iReq1;
        // On a tie the requester not served last wins; otherwise the only
        // active requester wins (req0 alone yields 0, req1 alone yields 1).
        if (iReq0 && iReq1) begin
            win_id = ~last_q;
        end else begin
            win_id = iReq1;
        end
        win_size = win_id ? iPktWdSize1 : iPktWdSize0;
        win_bad  = (win_size == 10'd0) || (win_size > SIZE_MAX);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_id_d = gnt_id_q;
        size_d   = size_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_id_d = win_id;
                    size_d   = win_size;
                    state_d  = win_bad ? ST_ERR : ST_START;
                end
            end
            ST_START: begin
                cnt_d   = 11'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 11'd1;
                // Engine completion wins over a coincident timeout.
                if (iDtCpDone) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: begin
                last_d  = gnt_id_q;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                last_d  = gnt_id_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so every output is a flop
    // ------------------------------------------------------------------
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        gnt0_d  = busy_d & ~gnt_id_d;
        gnt1_d  = busy_d &  gnt_id_d;
        st_d    = (state_d == ST_START);
        err_d   = (state_d == ST_ERR);
        done0_d = ((state_d == ST_DONE) || (state_d == ST_ERR)) & ~gnt_id_d;
        done1_d = ((state_d == ST_DONE) || (state_d == ST_ERR)) &  gnt_id_d;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state_q  <= ST_IDLE;
            // Requester 0 wins the first tie after reset.
            last_q   <= 1'b1;
            gnt_id_q <= 1'b0;
            size_q   <= 10'd0;
            cnt_q    <= 11'd0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
            st_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_id_q <= gnt_id_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err_q    <= err_d;
            st_q     <= st_d;
            busy_q   <= busy_d;
        end
    end

    assign oGnt0      = gnt0_q;
    assign oGnt1      = gnt1_q;
    assign oDone0     = done0_q;
    assign oDone1     = done1_q;
    assign oErr       = err_q;
    assign oStDtCp    = st_q;
    assign oBusy      = busy_q;
    assign oPktWdSize = size_q;

endmodule

// File: tb/tb_dtcp_arbiter.sv
module tb_dtcp_arbiter;

    logic       iClk = 1'b0;
    logic       iRsn = 1'b0;
    logic       iReq0 = 1'b0, iReq1 = 1'b0, iDtCpDone = 1'b0;
    logic [9:0] iPktWdSize0 = '0, iPktWdSize1 = '0;

    logic       oGnt0, oGnt1, oDone0, oDone1, oErr, oStDtCp, oBusy;
    logic [9:0] oPktWdSize;
    logic       tGnt0, tGnt1, tDone0, tDone1, tErr, tStDtCp, tBusy;
    logic [9:0] tPktWdSize;

    always #5 iClk = ~iClk;

    dtcp_arbiter dut (
        .iClk(iClk), .iRsn(iRsn),
        .iReq0(iReq0), .iPktWdSize0(iPktWdSize0), .oGnt0(oGnt0), .oDone0(oDone0),
        .iReq1(iReq1), .iPktWdSize1(iPktWdSize1), .oGnt1(oGnt1), .oDone1(oDone1),
        .oErr(oErr), .oStDtCp(oStDtCp), .oPktWdSize(oPktWdSize),
        .iDtCpDone(iDtCpDone), .oBusy(oBusy)
    );

    dtcp_arbiter #(.P_TOCYC(11'd16)) dut16 (
        .iClk(iClk), .iRsn(iRsn),
        .iReq0(iReq0), .iPktWdSize0(iPktWdSize0), .oGnt0(tGnt0), .oDone0(tDone0),
        .iReq1(iReq1), .iPktWdSize1(iPktWdSize1), .oGnt1(tGnt1), .oDone1(tDone1),
        .oErr(tErr), .oStDtCp(tStDtCp), .oPktWdSize(tPktWdSize),
        .iDtCpDone(iDtCpDone), .oBusy(tBusy)
    );

    typedef struct {
        logic       rsn, r0, r1;
        logic [9:0] s0, s1;
        logic       dd;
        logic       g0, g1, d0, d1, er, st, bz;
        logic [9:0] sz;
    } vec_t;

    typedef struct { logic id; logic err; } job_t;

    vec_t tbl[$];
    vec_t vexp_q[$];
    job_t job_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        iRsn = 1'b0; iReq0 = 1'b0; iReq1 = 1'b0; iDtCpDone = 1'b0;
        iPktWdSize0 = '0; iPktWdSize1 = '0;
        tick(); tick();
        iRsn = 1'b1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected job.
    always @(posedge iClk) begin
        #1;
        if (mon_en && (oDone0 || oDone1)) begin
            check("done_one_hot", {31'd0, oDone0 & oDone1}, 32'd0);
            if (job_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                job_t j;
                j = job_q.pop_front();
                check("sb_done_id", {31'd0, oDone1}, {31'd0, j.id});
                check("sb_done_err", {31'd0, oErr}, {31'd0, j.err});
            end
        end
    end

    initial begin
        vec_t v, e;
        int   k;
        int   done_cyc;
        logic st_seen;

        //            rsn  r0   r1   s0      s1      dd   g0   g1   d0   d1   er   st   bz   sz
        tbl.push_back('{1'b0,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b0,1'b1,1'b1,10'h010,10'h010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b1,1'b0,10'h010,10'h000,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,10'h010});
        tbl.push_back('{1'b1,1'b1,1'b0,10'h3FF,10'h000,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h010});
        tbl.push_back('{1'b1,1'b1,1'b0,10'h3FF,10'h000,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,10'h010});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h010});
        tbl.push_back('{1'b1,1'b0,1'b1,10'h000,10'h000,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,10'h000});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b1,1'b1,10'h200,10'h201,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,10'h200});
        tbl.push_back('{1'b1,1'b1,1'b1,10'h200,10'h201,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h200});
        tbl.push_back('{1'b1,1'b1,1'b1,10'h200,10'h201,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,10'h200});
        tbl.push_back('{1'b1,1'b0,1'b1,10'h000,10'h201,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h200});
        tbl.push_back('{1'b1,1'b0,1'b1,10'h000,10'h201,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,10'h201});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h201});
        tbl.push_back('{1'b1,1'b1,1'b0,10'h020,10'h000,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,10'h020});
        tbl.push_back('{1'b1,1'b1,1'b0,10'h020,10'h000,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,10'h020});
        tbl.push_back('{1'b0,1'b1,1'b0,10'h020,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});
        tbl.push_back('{1'b1,1'b0,1'b0,10'h000,10'h000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,10'h000});

        // Table-driven cycle vectors: expected outputs queued when driven.
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            iRsn = v.rsn; iReq0 = v.r0; iReq1 = v.r1;
            iPktWdSize0 = v.s0; iPktWdSize1 = v.s1; iDtCpDone = v.dd;
            vexp_q.push_back(v);
            tick();
            e = vexp_q.pop_front();
            check($sformatf("vec%0d", i),
                  {13'd0, oGnt0, oGnt1, oDone0, oDone1, oErr, oStDtCp, oBusy, oPktWdSize},
                  {13'd0, e.g0, e.g1, e.d0, e.d1, e.er, e.st, e.bz, e.sz});
        end

        mon_en = 1'b1;

        // Single job, engine answers 20 cycles after start.
        do_reset();
        iReq0 = 1'b1; iPktWdSize0 = 10'h010;
        job_q.push_back('{1'b0, 1'b0});
        tick();
        check("job_start_lat", {31'd0, oStDtCp}, 32'd1);
        check("job_size", {22'd0, oPktWdSize}, 32'h010);
        for (int i = 0; i < 19; i++) tick();
        check("job_no_early_done", {31'd0, oDone0}, 32'd0);
        iDtCpDone = 1'b1;
        tick();
        iDtCpDone = 1'b0; iReq0 = 1'b0;
        check("job_done_lat", {31'd0, oDone0}, 32'd1);
        check("job_err", {31'd0, oErr}, 32'd0);
        tick();
        check("job_idle", {31'd0, oBusy}, 32'd0);

        // Round robin with both requests held.
        do_reset();
        iReq0 = 1'b1; iReq1 = 1'b1; iPktWdSize0 = 10'h004; iPktWdSize1 = 10'h004;
        done_cyc = -100;
        for (int j = 0; j < 4; j++) begin
            k = 0;
            while (!oStDtCp && k < 10) begin tick(); k++; end
            check("rr_start_seen", {31'd0, oStDtCp}, 32'd1);
            check("rr_grant1", {31'd0, oGnt1}, j % 2);
            if (j > 0) check("rr_gap", {31'd0, (cyc - done_cyc) >= 2}, 32'd1);
            job_q.push_back('{(j % 2) == 1, 1'b0});
            tick();
            iDtCpDone = 1'b1;
            tick();
            iDtCpDone = 1'b0;
            if (j == 3) begin iReq0 = 1'b0; iReq1 = 1'b0; end
            done_cyc = cyc;
        end
        tick();

        // Illegal sizes: 0 and 0x201.
        iReq1 = 1'b1; iPktWdSize1 = 10'h000;
        job_q.push_back('{1'b1, 1'b1});
        tick();
        check("bad0_done_err", {30'd0, oDone1, oErr}, 32'd3);
        check("bad0_no_start", {31'd0, oStDtCp}, 32'd0);
        iReq1 = 1'b0;
        tick();
        check("bad0_no_start2", {31'd0, oStDtCp}, 32'd0);
        iReq1 = 1'b1; iPktWdSize1 = 10'h201;
        job_q.push_back('{1'b1, 1'b1});
        tick();
        check("bad201_done_err", {30'd0, oDone1, oErr}, 32'd3);
        check("bad201_no_start", {31'd0, oStDtCp}, 32'd0);
        iReq1 = 1'b0;
        tick();

        // Size change after grant is ignored until the next grant.
        do_reset();
        iReq0 = 1'b1; iPktWdSize0 = 10'h020;
        job_q.push_back('{1'b0, 1'b0});
        tick();
        tick();
        iPktWdSize0 = 10'h030;
        tick(); tick();
        check("size_hold_wait", {22'd0, oPktWdSize}, 32'h020);
        iDtCpDone = 1'b1;
        tick();
        iDtCpDone = 1'b0; iReq0 = 1'b0;
        tick();
        check("size_hold_idle", {22'd0, oPktWdSize}, 32'h020);
        iReq0 = 1'b1;
        job_q.push_back('{1'b0, 1'b0});
        tick();
        check("size_new_grant", {22'd0, oPktWdSize}, 32'h030);
        tick();
        iDtCpDone = 1'b1;
        tick();
        iDtCpDone = 1'b0; iReq0 = 1'b0;
        tick();
        check("sb_empty", job_q.size(), 32'd0);

        // Timeout on the P_TOCYC=16 instance.
        mon_en = 1'b0;
        do_reset();
        iReq0 = 1'b1; iPktWdSize0 = 10'h200;
        tick();
        check("to_start", {31'd0, tStDtCp}, 32'd1);
        k = 0; st_seen = 1'b0;
        while (!tDone0 && k < 40) begin
            tick(); k++;
            if (tStDtCp) st_seen = 1'b1;
        end
        check("to_latency", k, 32'd17);
        check("to_err", {31'd0, tErr}, 32'd1);
        check("to_no_start", {31'd0, st_seen}, 32'd0);
        iReq0 = 1'b0;
        tick();
        iReq0 = 1'b1; iPktWdSize0 = 10'h005;
        tick();
        check("to_new_job", {31'd0, tStDtCp}, 32'd1);
        check("to_new_size", {22'd0, tPktWdSize}, 32'h005);
        do_reset();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
